// File: rtl/matrix_result_drain_pkg.sv
// Shared state encoding and sizing helpers for the matrix result drain path.
package matrix_result_drain_pkg;

  localparam int DEFAULT_DIM        = 32'sd4;
  localparam int DEFAULT_DATA_WIDTH = 32'sd8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/matrix_result_drain_index_counter.sv
// Row-major element index with registered row, column and last-element flag.
module matrix_index_counter
  import matrix_result_drain_pkg::*;
#(
  parameter int DIM = DEFAULT_DIM
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           incr,
  output logic [cnt_width(DIM*DIM)-1:0]  idx,
  output logic [cnt_width(DIM)-1:0]      row,
  output logic [cnt_width(DIM)-1:0]      col,
  output logic                           last
);

  localparam int IW = cnt_width(DIM * DIM);
  localparam int RW = cnt_width(DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM * DIM - 1);
  localparam logic [RW-1:0] LAST_COL = RW'(DIM - 1);
  localparam logic          ONE_ELEM = (LAST_IDX == {IW{1'b0}});

  // Index state; increments are ignored once the last element is reached.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      row  <= '0;
      col  <= '0;
      last <= 1'b0;
    end else if (clear) begin
      idx  <= '0;
      row  <= '0;
      col  <= '0;
      last <= ONE_ELEM;
    end else if (incr && !last) begin
      idx  <= idx + 1'b1;
      last <= ((idx + 1'b1) == LAST_IDX);
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
        row <= row;
      end
    end else begin
      idx  <= idx;
      row  <= row;
      col  <= col;
      last <= last;
    end
  end

endmodule

// File: rtl/matrix_result_drain.sv
// Snapshots the MAC accumulator matrix and streams it out row-major over valid/ready.
module matrix_result_drain
  import matrix_result_drain_pkg::*;
#(
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int DIM              = DEFAULT_DIM,
  parameter bit CLEAR_ON_CAPTURE = 1'b1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DIM*DIM*DATA_WIDTH-1:0]   mac_result,
  output logic                            mac_clear,
  output logic                            busy,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [cnt_width(DIM)-1:0]       out_row,
  output logic [cnt_width(DIM)-1:0]       out_col,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done
);

  localparam int N  = DIM * DIM;
  localparam int IW = cnt_width(N);

  drain_state_e          state_r;
  logic [DATA_WIDTH-1:0] snapshot_r [N];
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [DATA_WIDTH-1:0] next_data_s;
  logic                  out_valid_r;
  logic                  mac_clear_r;
  logic                  done_r;
  logic [IW-1:0]         idx_s;
  logic [IW-1:0]         next_idx_s;
  logic                  last_s;
  logic                  capture_s;
  logic                  xfer_s;
  logic                  final_s;
  logic                  step_s;

  assign capture_s = (state_r == ST_IDLE) && start;
  assign xfer_s    = out_valid_r && out_ready;
  assign final_s   = xfer_s && last_s;
  assign step_s    = xfer_s && !last_s;

  // Clearing on the final transfer parks row/col/last at zero between drains.
  matrix_index_counter #(.DIM(DIM)) u_index (
    .clock (clock),
    .reset (reset),
    .clear (capture_s || final_s),
    .incr  (step_s),
    .idx   (idx_s),
    .row   (out_row),
    .col   (out_col),
    .last  (last_s)
  );

  // Element that becomes current after a non-final transfer.
  always_comb begin
    next_idx_s  = idx_s + 1'b1;
    next_data_s = snapshot_r[next_idx_s];
  end

  // Parallel snapshot of the whole accumulator, isolated from later MAC activity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        snapshot_r[i] <= '0;
      end
    end else if (capture_s) begin
      for (int i = 0; i < N; i++) begin
        snapshot_r[i] <= mac_result[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        snapshot_r[i] <= snapshot_r[i];
      end
    end
  end

  // Drain FSM; element 0 comes straight from the bus since the snapshot loads on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      mac_clear_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      mac_clear_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            state_r     <= ST_STREAM;
            out_valid_r <= 1'b1;
            out_data_r  <= mac_result[DATA_WIDTH-1:0];
            mac_clear_r <= CLEAR_ON_CAPTURE;
          end else begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
          end
        end
        ST_STREAM: begin
          if (final_s) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            done_r      <= 1'b1;
          end else if (step_s) begin
            state_r     <= ST_STREAM;
            out_valid_r <= 1'b1;
            out_data_r  <= next_data_s;
          end else begin
            state_r     <= ST_STREAM;
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_r == ST_STREAM);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = last_s;
  assign mac_clear = mac_clear_r;
  assign done      = done_r;

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain: an 8-bit clearing instance and a 16-bit non-clearing instance.
module tb_matrix_result_drain;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         start_a, clear_a, busy_a, last_a, valid_a, ready_a, done_a;
  logic [127:0] mac_a;
  logic [7:0]   data_a;
  logic [1:0]   row_a, col_a;

  logic         start_b, clear_b, busy_b, last_b, valid_b, ready_b, done_b;
  logic [255:0] mac_b;
  logic [15:0]  data_b;
  logic [1:0]   row_b, col_b;

  logic [16:0]  obs_a;
  logic [24:0]  obs_b;
  assign obs_a = {valid_a, data_a, row_a, col_a, last_a, clear_a, done_a, busy_a};
  assign obs_b = {valid_b, data_b, row_b, col_b, last_b, clear_b, done_b, busy_b};

  int n_cmp = 0;
  int n_err = 0;

  matrix_result_drain #(.DATA_WIDTH(8), .DIM(4), .CLEAR_ON_CAPTURE(1'b1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mac_result(mac_a),
    .mac_clear(clear_a), .busy(busy_a), .out_data(data_a), .out_row(row_a),
    .out_col(col_a), .out_last(last_a), .out_valid(valid_a), .out_ready(ready_a),
    .done(done_a)
  );

  matrix_result_drain #(.DATA_WIDTH(16), .DIM(4), .CLEAR_ON_CAPTURE(1'b0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .mac_result(mac_b),
    .mac_clear(clear_b), .busy(busy_b), .out_data(data_b), .out_row(row_b),
    .out_col(col_b), .out_last(last_b), .out_valid(valid_b), .out_ready(ready_b),
    .done(done_b)
  );

  task automatic load_mac_a_ramp();
    for (int i = 0; i < 16; i++) mac_a[i*8 +: 8] = 8'(i + 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs_a !== 17'h0 || obs_b !== 25'h0) begin
      n_err++;
      $display("FAIL reset_initial got a=%h b=%h want a=0 b=0", obs_a, obs_b);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (obs_a !== 17'h0) begin
      n_err++;
      $display("FAIL reset_idle got %h want 0", obs_a);
    end
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (obs_a !== {1'b1, 8'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_prestream got %h want %h", obs_a, {1'b1, 8'd2, 2'd0, 2'd1, 4'b0001});
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs_a !== 17'h0) begin
      n_err++;
      $display("FAIL reset_async got %h want 0", obs_a);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (obs_a !== 17'h0) begin
      n_err++;
      $display("FAIL reset_release got %h want 0", obs_a);
    end
  endtask

  task automatic test_basic_drain();
    logic [16:0] exp_v;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, 8'(k + 1), 2'(k / 4), 2'(k % 4), k == 15, k == 0, 1'b0, 1'b1};
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL basic k=%0d got %h want %h", k, obs_a, exp_v);
      end
      @(negedge clock);
    end
    n_cmp++;
    if ({valid_a, done_a, busy_a} !== 3'b010) begin
      n_err++;
      $display("FAIL basic_done got v/d/b=%b want 010", {valid_a, done_a, busy_a});
    end
    @(negedge clock);
    n_cmp++;
    if ({valid_a, done_a, busy_a, clear_a} !== 4'b0000) begin
      n_err++;
      $display("FAIL basic_after got v/d/b/c=%b want 0000", {valid_a, done_a, busy_a, clear_a});
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp_v;
    int xfers = 0;
    int cyc = 0;
    ready_a = 1'b0;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    while (xfers < 16 && cyc < 40) begin
      ready_a = (cyc % 2 == 0);
      exp_v = {1'b1, 8'(xfers + 1), 2'(xfers / 4), 2'(xfers % 4), xfers == 15, cyc == 0, 1'b0, 1'b1};
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL backpressure cyc=%0d got %h want %h", cyc, obs_a, exp_v);
      end
      if (ready_a) xfers++;
      cyc++;
      @(negedge clock);
    end
    ready_a = 1'b1;
    n_cmp++;
    if (xfers != 16 || cyc != 31) begin
      n_err++;
      $display("FAIL backpressure_count got %0d xfers in %0d cycles want 16 in 31", xfers, cyc);
    end
    n_cmp++;
    if ({valid_a, done_a, busy_a} !== 3'b010) begin
      n_err++;
      $display("FAIL backpressure_done got v/d/b=%b want 010", {valid_a, done_a, busy_a});
    end
    @(negedge clock);
  endtask

  task automatic test_isolation();
    logic [16:0] exp_v;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, 8'(k + 1), 2'(k / 4), 2'(k % 4), k == 15, k == 0, 1'b0, 1'b1};
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL isolation k=%0d got %h want %h", k, obs_a, exp_v);
      end
      start_a = (k == 3);
      if (k == 3) begin
        for (int i = 0; i < 16; i++) mac_a[i*8 +: 8] = 8'hAA;
      end
      @(negedge clock);
    end
    n_cmp++;
    if ({valid_a, done_a, busy_a} !== 3'b010) begin
      n_err++;
      $display("FAIL isolation_done got v/d/b=%b want 010", {valid_a, done_a, busy_a});
    end
    load_mac_a_ramp();
    @(negedge clock);
  endtask

  task automatic test_abort();
    logic [16:0] exp_v;
    bit found = 1'b0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clock);
    n_cmp++;
    if (obs_a !== {1'b1, 8'd6, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL abort_pre got %h want %h", obs_a, {1'b1, 8'd6, 2'd1, 2'd1, 4'b0001});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs_a !== 17'h0) begin
      n_err++;
      $display("FAIL abort_reset got %h want 0", obs_a);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_cmp++;
      if (obs_a !== 17'h0) begin
        n_err++;
        $display("FAIL abort_nodone k=%0d got %h want 0", k, obs_a);
      end
    end
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    exp_v = {1'b1, 8'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (obs_a !== exp_v) begin
      n_err++;
      $display("FAIL abort_restart got %h want %h", obs_a, exp_v);
    end
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clock);
      if (done_a === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL abort_timeout got no done within 20 cycles want done");
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_v;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16; k++) begin
        exp_v = {1'b1, 8'(k + 1), 2'(k / 4), 2'(k % 4), k == 15, k == 0, 1'b0, 1'b1};
        n_cmp++;
        if (obs_a !== exp_v) begin
          n_err++;
          $display("FAIL b2b s=%0d k=%0d got %h want %h", s, k, obs_a, exp_v);
        end
        @(negedge clock);
      end
      n_cmp++;
      if ({valid_a, done_a, busy_a} !== 3'b010) begin
        n_err++;
        $display("FAIL b2b_done s=%0d got v/d/b=%b want 010", s, {valid_a, done_a, busy_a});
      end
      start_a = (s == 0);
      @(negedge clock);
      start_a = 1'b0;
    end
    n_cmp++;
    if ({valid_a, done_a, busy_a} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b_idle got v/d/b=%b want 000", {valid_a, done_a, busy_a});
    end
  endtask

  task automatic test_param();
    logic [24:0] exp_v;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_v = {1'b1, 16'hFFFF, 2'(k / 4), 2'(k % 4), k == 15, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (obs_b !== exp_v) begin
        n_err++;
        $display("FAIL param k=%0d got %h want %h", k, obs_b, exp_v);
      end
      @(negedge clock);
    end
    n_cmp++;
    if ({valid_b, done_b, busy_b, clear_b} !== 4'b0100) begin
      n_err++;
      $display("FAIL param_done got v/d/b/c=%b want 0100", {valid_b, done_b, busy_b, clear_b});
    end
    @(negedge clock);
  endtask

  initial begin
    start_a = 1'b0;
    ready_a = 1'b0;
    start_b = 1'b0;
    ready_b = 1'b1;
    mac_b   = '1;
    load_mac_a_ramp();
    #1;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_isolation();
    test_abort();
    test_back_to_back();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no completion want summary before 100us");
    $fatal(1, "watchdog expired");
  end

endmodule
